// File: rtl/ctrl_pipe_pkg.sv
// Shared control encodings for the pipeline control path.
// ALU operation and writeback-select enums used by ID/EX/MEM/WB stages.
package ctrl_pipe_pkg;

    typedef enum logic [3:0] {
        ALUOP_NONE = 4'd0,
        ALUOP_ADD  = 4'd1,
        ALUOP_SUB  = 4'd2,
        ALUOP_AND  = 4'd3,
        ALUOP_OR   = 4'd4,
        ALUOP_XOR  = 4'd5,
        ALUOP_SLT  = 4'd6,
        ALUOP_SLTU = 4'd7,
        ALUOP_SLL  = 4'd8,
        ALUOP_SRL  = 4'd9,
        ALUOP_SRA  = 4'd10,
        ALUOP_LUI  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC   = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Carries decoded control ID->EX->MEM->WB; load-use stall, redirect flush,
// data-memory freeze. Inputs: id_* bundle, ex_redirect_i, mem_stall_i.
// Outputs: ex_*/mem_*/wb_* stage control, stall_o, flush_ifid_o and
// statistics counters (real only when HAZARD_STATS_EN is defined).
module ctrl_pipe_hazard_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic                  id_ALUSrcA_i,
    input  logic                  id_ALUSrcB_i,
    input  logic                  id_Branch_i,
    input  logic                  id_Jump_i,
    input  logic                  id_MemWrite_i,
    input  logic                  id_MemRead_i,
    input  logic                  id_RegWrite_i,
    input  alu_op_e               id_ALUOp_i,
    input  wb_sel_e               id_WBSel_i,
    input  logic                  ex_redirect_i,
    input  logic                  mem_stall_i,
    output logic                  ex_valid_o,
    output logic                  ex_ALUSrcA_o,
    output logic                  ex_ALUSrcB_o,
    output logic                  ex_Branch_o,
    output logic                  ex_Jump_o,
    output logic                  ex_MemWrite_o,
    output logic                  ex_MemRead_o,
    output logic                  ex_RegWrite_o,
    output alu_op_e               ex_ALUOp_o,
    output wb_sel_e               ex_WBSel_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  mem_valid_o,
    output logic                  mem_MemWrite_o,
    output logic                  mem_MemRead_o,
    output logic                  mem_RegWrite_o,
    output wb_sel_e               mem_WBSel_o,
    output logic [REG_ADDR_W-1:0] mem_rd_o,
    output logic                  wb_valid_o,
    output logic                  wb_RegWrite_o,
    output wb_sel_e               wb_WBSel_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  stall_o,
    output logic                  flush_ifid_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      retire_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic                  aluSrcA;
        logic                  aluSrcB;
        logic                  branch;
        logic                  jump;
        logic                  memWrite;
        logic                  memRead;
        logic                  regWrite;
        alu_op_e               aluOp;
        wb_sel_e               wbSel;
        logic [REG_ADDR_W-1:0] rd;
    } exCtrl_t;

    typedef struct packed {
        logic                  valid;
        logic                  memWrite;
        logic                  memRead;
        logic                  regWrite;
        wb_sel_e               wbSel;
        logic [REG_ADDR_W-1:0] rd;
    } memCtrl_t;

    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        wb_sel_e               wbSel;
        logic [REG_ADDR_W-1:0] rd;
    } wbCtrl_t;

    localparam exCtrl_t EX_BUBBLE = '{
        valid: 1'b0, aluSrcA: 1'b0, aluSrcB: 1'b0,
        branch: 1'b0, jump: 1'b0, memWrite: 1'b0,
        memRead: 1'b0, regWrite: 1'b0,
        aluOp: ALUOP_NONE, wbSel: WB_NONE, rd: '0
    };
    localparam memCtrl_t MEM_BUBBLE = '{
        valid: 1'b0, memWrite: 1'b0, memRead: 1'b0,
        regWrite: 1'b0, wbSel: WB_NONE, rd: '0
    };
    localparam wbCtrl_t WB_BUBBLE = '{
        valid: 1'b0, regWrite: 1'b0,
        wbSel: WB_NONE, rd: '0
    };

    exCtrl_t  exQ, exNext, idCtrl;
    memCtrl_t memQ, memNext, exToMem;
    wbCtrl_t  wbQ, wbNext, memToWb;

    logic luHit;
    logic freeze, redirect, luStall, advance;

    always_comb begin
        idCtrl = EX_BUBBLE;
        if (id_valid_i) begin
            idCtrl = '{
                valid: 1'b1,
                aluSrcA: id_ALUSrcA_i,
                aluSrcB: id_ALUSrcB_i,
                branch: id_Branch_i,
                jump: id_Jump_i,
                memWrite: id_MemWrite_i,
                memRead: id_MemRead_i,
                regWrite: id_RegWrite_i,
                aluOp: id_ALUOp_i,
                wbSel: id_WBSel_i,
                rd: id_rd_i
            };
        end
    end

    always_comb begin
        exToMem = '{
            valid: exQ.valid,
            memWrite: exQ.memWrite,
            memRead: exQ.memRead,
            regWrite: exQ.regWrite,
            wbSel: exQ.wbSel,
            rd: exQ.rd
        };
        memToWb = '{
            valid: memQ.valid,
            regWrite: memQ.regWrite,
            wbSel: memQ.wbSel,
            rd: memQ.rd
        };
    end

    // Only a register-writing load to a nonzero rd can create a hazard.
    always_comb begin
        luHit = exQ.valid && exQ.memRead && exQ.regWrite
             && (exQ.rd != '0) && id_valid_i
             && ((id_use_rs1_i && (id_rs1_i == exQ.rd))
              || (id_use_rs2_i && (id_rs2_i == exQ.rd)));
    end

    // Priority folded into mutually exclusive selects.
    always_comb begin
        freeze   = mem_stall_i;
        redirect = !mem_stall_i && ex_redirect_i;
        luStall  = !mem_stall_i && !ex_redirect_i && luHit;
        advance  = !mem_stall_i && !ex_redirect_i && !luHit;
    end

    always_comb begin
        exNext  = exQ;
        memNext = memQ;
        wbNext  = wbQ;
        unique case (1'b1)
            freeze: begin
                exNext  = exQ;
            end
            redirect, luStall: begin
                exNext  = EX_BUBBLE;
                memNext = exToMem;
                wbNext  = memToWb;
            end
            advance: begin
                exNext  = idCtrl;
                memNext = exToMem;
                wbNext  = memToWb;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exQ  <= EX_BUBBLE;
            memQ <= MEM_BUBBLE;
            wbQ  <= WB_BUBBLE;
        end else begin
            exQ  <= exNext;
            memQ <= memNext;
            wbQ  <= wbNext;
        end
    end

    // Hazard outputs are forced low while reset is held.
    assign stall_o      = !rst_i && (freeze || luStall);
    assign flush_ifid_o = !rst_i && redirect;

    assign ex_valid_o    = exQ.valid;
    assign ex_ALUSrcA_o  = exQ.valid && exQ.aluSrcA;
    assign ex_ALUSrcB_o  = exQ.valid && exQ.aluSrcB;
    assign ex_Branch_o   = exQ.valid && exQ.branch;
    assign ex_Jump_o     = exQ.valid && exQ.jump;
    assign ex_MemWrite_o = exQ.valid && exQ.memWrite;
    assign ex_MemRead_o  = exQ.valid && exQ.memRead;
    assign ex_RegWrite_o = exQ.valid && exQ.regWrite;
    assign ex_ALUOp_o    = exQ.aluOp;
    assign ex_WBSel_o    = exQ.wbSel;
    assign ex_rd_o       = exQ.rd;

    assign mem_valid_o    = memQ.valid;
    assign mem_MemWrite_o = memQ.valid && memQ.memWrite;
    assign mem_MemRead_o  = memQ.valid && memQ.memRead;
    assign mem_RegWrite_o = memQ.valid && memQ.regWrite;
    assign mem_WBSel_o    = memQ.wbSel;
    assign mem_rd_o       = memQ.rd;

    assign wb_valid_o    = wbQ.valid;
    assign wb_RegWrite_o = wbQ.valid && wbQ.regWrite;
    assign wb_WBSel_o    = wbQ.wbSel;
    assign wb_rd_o       = wbQ.rd;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stallCnt, flushCnt, retireCnt;

    // Saturating counters: hold at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stallCnt  <= '0;
            flushCnt  <= '0;
            retireCnt <= '0;
        end else begin
            if (stall_o && (stallCnt != '1))
                stallCnt <= stallCnt + CNT_W'(1);
            if (flush_ifid_o && (flushCnt != '1))
                flushCnt <= flushCnt + CNT_W'(1);
            if (wbQ.valid && !mem_stall_i && (retireCnt != '1))
                retireCnt <= retireCnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o  = stallCnt;
    assign flush_cnt_o  = flushCnt;
    assign retire_cnt_o = retireCnt;
`else
    assign stall_cnt_o  = '0;
    assign flush_cnt_o  = '0;
    assign retire_cnt_o = '0;
`endif

endmodule

// File: doc/ctrl_pipe_hazard_unit.md
Name: ctrl_pipe_hazard_unit

Overview:
- Consumer of the decoded control bundle from the main control unit.
- Carries the control signals and rd address from ID through EX, MEM and WB pipeline registers.
- Detects load-use hazards and stalls the front end while inserting a bubble.
- Applies flushes on EX-resolved redirects (taken branch or jump) and freezes on data-memory wait.

Parameters:
REG_ADDR_W, 5, register address width
CNT_W, 32, width of statistics counters (optional feature only)

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous, active-high reset
id_valid_i  in  1  ID stage holds a valid instruction
id_rs1_i / id_rs2_i / id_rd_i  in  REG_ADDR_W each  ID register addresses
id_use_rs1_i / id_use_rs2_i  in  1 each  instruction reads rs1 / rs2
id_ALUSrcA_i, id_ALUSrcB_i, id_Branch_i, id_Jump_i, id_MemWrite_i, id_MemRead_i, id_RegWrite_i  in  1 each  decoded control
id_ALUOp_i  in  alu_op_e  decoded ALU op
id_WBSel_i  in  wb_sel_e  decoded writeback select
ex_redirect_i  in  1  EX resolved taken branch/jump this cycle
mem_stall_i  in  1  data memory not ready; freeze pipeline
ex_* / mem_* / wb_*  out  same widths as id_*  registered control per stage: EX gets all fields; MEM gets MemWrite, MemRead, RegWrite, WBSel; WB gets RegWrite, WBSel
ex_valid_o, mem_valid_o, wb_valid_o  out  1 each  stage valid
ex_rd_o, mem_rd_o, wb_rd_o  out  REG_ADDR_W each  per-stage destination
stall_o  out  1  hold PC and IF/ID register
flush_ifid_o  out  1  invalidate IF/ID register
stall_cnt_o, flush_cnt_o, retire_cnt_o  out  CNT_W each  statistics (optional feature)

Behaviour:
- Reset (async, immediate): all stage valids = 0; all 1-bit controls = 0; ALUOp = ALUOP_NONE; WBSel = WB_NONE; rd = 0. stall_o and flush_ifid_o are combinational and evaluate to 0 while in reset.
- Bubble definition: valid = 0, all 1-bit controls = 0, ALUOp = ALUOP_NONE, WBSel = WB_NONE, rd = 0.
- Stage control outputs are gated with the stage valid: an invalid stage never presents RegWrite, MemWrite or MemRead = 1.
- Load-use hazard (combinational), lu = all of:
  - ex_valid_o & ex_MemRead_o & ex_RegWrite_o & (ex_rd_o != 0) & id_valid_i
  - and ((id_use_rs1_i & id_rs1_i == ex_rd_o) | (id_use_rs2_i & id_rs2_i == ex_rd_o)).
- Priority per cycle, highest first:
  1. mem_stall_i = 1:
     - all four stage registers hold; stall_o = 1; flush_ifid_o = 0.
     - A redirect arriving during the freeze is ignored; the producer keeps ex_redirect_i high while EX is frozen.
  2. ex_redirect_i = 1:
     - a bubble loads into EX (the ID instruction is killed); flush_ifid_o = 1; stall_o = 0.
     - MEM <= EX and WB <= MEM advance normally. The redirecting instruction itself continues to MEM.
     - lu is ignored.
  3. lu = 1:
     - a bubble loads into EX; stall_o = 1; flush_ifid_o = 0; MEM and WB advance.
     - The stall is exactly 1 cycle because the load moves to MEM.
  4. Otherwise:
     - EX <= ID fields with valid = id_valid_i; MEM <= EX; WB <= MEM.
     - An ID slot with id_valid_i = 0 becomes a bubble.
- Latency: ID to EX outputs is 1 cycle, ID to MEM is 2 cycles, ID to WB is 3 cycles, with no stalls.
- rd = 0 is never treated as a hazard source. rs compare uses the full REG_ADDR_W bits.
- Back-to-back load-use across 2 consecutive IDs: each produces its own independent single-cycle stall.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stall_cnt_o increments on every cycle with stall_o = 1.
  - flush_cnt_o increments on every cycle with flush_ifid_o = 1.
  - retire_cnt_o increments on every cycle in which wb_valid_o = 1 and mem_stall_i = 0.
  - All three saturate at 2^CNT_W-1 (no wrap) and reset to 0.
- Not defined: all three ports are driven constant 0 and no counter flops exist.

Test Plan:
- Straight-line: R-type (RegWrite = 1, WBSel = WB_ALU, rd = 5) at ID in cycle 0 -> ex_* in cycle 1, mem_* in cycle 2, wb_RegWrite_o = 1 and wb_rd_o = 5 in cycle 3; stall_o = 0 throughout.
- Load-use: LOAD with rd = 3 followed by ADD with rs1 = 3 -> stall_o = 1 for exactly 1 cycle; EX holds a bubble (ex_valid_o = 0, ex_RegWrite_o = 0); ADD reaches EX one cycle later.
- Load with rd = 0 followed by a use of rs1 = 0, and load with rd = 3 followed by an instruction with id_use_rs1_i = 0 and rs1 = 3 -> no stall in either case.
- Redirect with concurrent lu: ex_redirect_i = 1 and lu condition true in the same cycle -> flush_ifid_o = 1, stall_o = 0, EX bubble, MEM receives the branch (mem_valid_o = 1).
- Freeze: mem_stall_i high for 3 cycles with a valid load in MEM -> all stage outputs constant, stall_o = 1, no flush; the pipeline resumes on the cycle after deassertion.
- Async reset asserted mid-stream (between clock edges) -> all valids and controls go to 0 immediately. With HAZARD_STATS_EN: counters return to 0; a run of 1 lu stall plus 1 flush reads stall_cnt_o = 1 and flush_cnt_o = 1.
